// File: rtl/downsample_ctrl_pkg.sv
// Shared FSM encoding and per-output cycle constants
// for the binary-frame block downsampler.
package downsample_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    AVG,
    OUT,
    FIN
  } state_e;

  // FETCH spans N read cycles plus one to land the last read
  localparam int FETCH_EXTRA    = 1;
  localparam int AVG_CYCLES     = 1;
  localparam int OUT_MIN_CYCLES = 1;

  function automatic int cycles_per_out(input int n);
    return n + FETCH_EXTRA + AVG_CYCLES + OUT_MIN_CYCLES;
  endfunction

endpackage

// File: rtl/average_n_pixels.sv
// Registered average of n binary pixels, scaled to
// output_resolution bits: (ones * (2^(R-1)-1)) >> log2(n).
module average_n_pixels #(
  parameter int n                 = 4,
  parameter int output_resolution = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [n-1:0]                 pixels,
  output logic [output_resolution-1:0] avg
);

  localparam int CW = $clog2(n + 1);
  localparam int LN = $clog2(n);
  localparam int PW = CW + output_resolution;
  localparam logic [PW-1:0] SCALE =
    PW'((1 << (output_resolution - 1)) - 1);

  logic [CW-1:0]                ones;
  logic [PW-1:0]                prod;
  logic [output_resolution-1:0] avg_d;
  logic [output_resolution-1:0] avg_q;

  always_comb begin
    ones = '0;
    for (int i = 0; i < n; i++) begin
      ones = ones + CW'(pixels[i]);
    end
    prod  = PW'(ones) * SCALE;
    avg_d = avg_q;
    if (en) begin
      avg_d = output_resolution'(prod >> LN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avg_q <= '0;
    end else begin
      avg_q <= avg_d;
    end
  end

  assign avg = avg_q;

endmodule

// File: rtl/downsample_ctrl.sv
// Walks a binary frame in BxB blocks, fetches each block
// from 1-cycle-latency memory and emits one averaged pixel.
module downsample_ctrl
  import downsample_ctrl_pkg::*;
#(
  parameter int IN_W    = 56,
  parameter int IN_H    = 56,
  parameter int B       = 2,
  parameter int OUT_RES = 8,
  localparam int OUT_W  = IN_W / B,
  localparam int OUT_H  = IN_H / B,
  localparam int AW     = $clog2(IN_W * IN_H),
  localparam int OW     = $clog2(OUT_W * OUT_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      mem_addr,
  input  logic               mem_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_RES-1:0] out_pixel,
  output logic [OW-1:0]      out_addr
);

  localparam int N  = B * B;
  localparam int LN = $clog2(N);
  localparam int KW = (LN > 0) ? LN : 1;
  localparam int CW = $clog2(N + FETCH_EXTRA);
  localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   bx_q, bx_d;
  logic [YW-1:0]   by_q, by_d;
  logic [N-1:0]    pix_q, pix_d;
  logic [KW-1:0]   k_prev;
  logic            avg_en;
  logic            last_blk;
  logic            row_end;
  int              row;
  int              col;

  assign row_end  = (bx_q == XW'(OUT_W - 1));
  assign last_blk = row_end && (by_q == YW'(OUT_H - 1));
  assign k_prev   = KW'(cnt_q - 1'b1);

  always_comb begin
    row      = int'(by_q) * B + int'(cnt_q) / B;
    col      = int'(bx_q) * B + int'(cnt_q) % B;
    mem_addr = '0;
    if (state_q == FETCH && cnt_q < CW'(N)) begin
      mem_addr = AW'(row * IN_W + col);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    pix_d   = pix_q;
    avg_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
          bx_d    = '0;
          by_d    = '0;
        end
      end
      FETCH: begin
        if (cnt_q != '0) begin
          pix_d[k_prev] = mem_rd_data;
        end
        if (cnt_q == CW'(N + FETCH_EXTRA - 1)) begin
          state_d = AVG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      AVG: begin
        avg_en  = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          cnt_d = '0;
          if (last_blk) begin
            state_d = FIN;
            bx_d    = '0;
            by_d    = '0;
          end else begin
            state_d = FETCH;
            if (row_end) begin
              bx_d = '0;
              by_d = by_q + 1'b1;
            end else begin
              bx_d = bx_q + 1'b1;
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      pix_q   <= pix_d;
    end
  end

  average_n_pixels #(
    .n                 (N),
    .output_resolution (OUT_RES)
  ) u_avg (
    .clk    (clk),
    .reset  (reset),
    .en     (avg_en),
    .pixels (pix_q),
    .avg    (out_pixel)
  );

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_valid = (state_q == OUT);
  assign out_addr  = OW'(int'(by_q) * OUT_W + int'(bx_q));

endmodule

// File: tb/tb_downsample_ctrl.sv
// Directed bench: B=2 and B=4 instances, memory models,
// and output scoreboards fed from the bench's frame model.
module tb_downsample_ctrl;

  typedef struct {
    int addr;
    int pix;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b;
  logic       ready_a, ready_b;
  logic       rd_a, rd_b;
  logic       busy_a, done_a, ov_a;
  logic       busy_b, done_b, ov_b;
  logic [11:0] ma_a, ma_b;
  logic [7:0] px_a, px_b;
  logic [9:0] oa_a;
  logic [7:0] oa_b;

  bit   mem_a [0:3135];
  bit   mem_b [0:3135];
  exp_t qa [$];
  exp_t qb [$];
  exp_t ea, eb;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_acc_a = 0, n_acc_b = 0;
  int   done_cnt_a = 0, done_cnt_b = 0;
  int   t_last_a = 0;
  bit   mon_a = 0, mon_b = 0;

  downsample_ctrl #(
    .IN_W(56), .IN_H(56), .B(2), .OUT_RES(8)
  ) dut_a (
    .clk         (clk),
    .reset       (reset),
    .start       (start_a),
    .busy        (busy_a),
    .done        (done_a),
    .mem_addr    (ma_a),
    .mem_rd_data (rd_a),
    .out_valid   (ov_a),
    .out_ready   (ready_a),
    .out_pixel   (px_a),
    .out_addr    (oa_a)
  );

  downsample_ctrl #(
    .IN_W(56), .IN_H(56), .B(4), .OUT_RES(8)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .start       (start_b),
    .busy        (busy_b),
    .done        (done_b),
    .mem_addr    (ma_b),
    .mem_rd_data (rd_b),
    .out_valid   (ov_b),
    .out_ready   (ready_b),
    .out_pixel   (px_b),
    .out_addr    (oa_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_a <= mem_a[ma_a];
    rd_b <= mem_b[ma_b];
    cyc  <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (mon_a && ov_a && ready_a) begin
      chk("sb_a_nonempty", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("out_addr_a", oa_a, ea.addr);
        chk("out_pixel_a", px_a, ea.pix);
      end
      n_acc_a++;
      t_last_a = cyc + 1;
    end
    if (mon_b && ov_b && ready_b) begin
      chk("sb_b_nonempty", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("out_addr_b", oa_b, eb.addr);
        chk("out_pixel_b", px_b, eb.pix);
      end
      n_acc_b++;
    end
  end

  // Expected outputs computed straight from the memory image
  task automatic push_frame(input bit which);
    int bb, ow, c, sh;
    bb = which ? 4 : 2;
    ow = 56 / bb;
    sh = which ? 4 : 2;
    for (int y = 0; y < ow; y++) begin
      for (int x = 0; x < ow; x++) begin
        c = 0;
        for (int dy = 0; dy < bb; dy++) begin
          for (int dx = 0; dx < bb; dx++) begin
            if (which)
              c += int'(mem_b[(y*bb+dy)*56 + x*bb+dx]);
            else
              c += int'(mem_a[(y*bb+dy)*56 + x*bb+dx]);
          end
        end
        if (which)
          qb.push_back('{y*ow + x, (c*127) >> sh});
        else
          qa.push_back('{y*ow + x, (c*127) >> sh});
      end
    end
  endtask

  task automatic wait_done(input bit which,
                           input int target,
                           input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((which ? done_cnt_b : done_cnt_a) >= target)
        break;
      tick();
    end
    chk("done_seen",
        (which ? done_cnt_b : done_cnt_a) >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int tab [5];
    int pos [4];
    int lat, base_acc, base_done, t_start, exp_pix;
    tab = '{0, 31, 63, 95, 127};
    pos = '{0, 1, 56, 57};
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_valid", ov_a, 0);
    chk("rst_mem_addr", ma_a, 0);
    chk("rst_out_addr", oa_a, 0);
    chk("rst_out_pixel", px_a, 0);
    chk("rst_busy_b", busy_b, 0);

    // First block with 0..4 ones
    for (int ones = 0; ones < 5; ones++) begin
      foreach (mem_a[i]) mem_a[i] = 1'b0;
      for (int i = 0; i < ones; i++) mem_a[pos[i]] = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      lat = 0;
      while (!ov_a && lat < 20) begin
        tick();
        lat++;
      end
      chk("first_latency", lat, 6);
      chk("blk0_addr", oa_a, 0);
      chk("blk0_pixel", px_a, tab[ones]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
    end

    // All-ones frame, ready tied high
    foreach (mem_a[i]) mem_a[i] = 1'b1;
    push_frame(0);
    base_acc  = n_acc_a;
    base_done = done_cnt_a;
    mon_a     = 1'b1;
    start_a   = 1'b1;
    tick();
    start_a = 1'b0;
    t_start = cyc;
    wait_done(0, base_done + 1, 6000);
    repeat (5) tick();
    chk("ones_outputs", n_acc_a - base_acc, 784);
    chk("ones_done_once", done_cnt_a - base_done, 1);
    chk("ones_queue_empty", qa.size(), 0);
    chk("ones_cycles", t_last_a - t_start, 784 * 7);

    // Random frame, stall at addr 5, start while busy
    foreach (mem_a[i]) mem_a[i] = 1'($urandom_range(0, 1));
    push_frame(0);
    base_acc  = n_acc_a;
    base_done = done_cnt_a;
    start_a   = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ov_a && oa_a == 10'd4) break;
      tick();
    end
    chk("reach_addr4", ov_a && oa_a == 10'd4, 1);
    tick();
    ready_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ov_a) break;
      tick();
    end
    exp_pix = (qa.size() != 0) ? qa[0].pix : -1;
    for (int s = 0; s < 10; s++) begin
      chk("stall_valid", ov_a, 1);
      chk("stall_addr", oa_a, 5);
      chk("stall_pixel", px_a, exp_pix);
      chk("stall_no_read", ma_a, 0);
      start_a = (s == 3);
      tick();
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    repeat (3) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, base_done + 1, 6000);
    repeat (20) tick();
    chk("stall_outputs", n_acc_a - base_acc, 784);
    chk("busy_start_one_done", done_cnt_a - base_done, 1);
    chk("busy_start_idle", busy_a, 0);
    chk("stall_queue_empty", qa.size(), 0);

    // Reset during FETCH of block 100
    foreach (mem_a[i]) mem_a[i] = 1'b1;
    push_frame(0);
    base_acc  = n_acc_a;
    base_done = done_cnt_a;
    start_a   = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!ov_a && ma_a != 0 && oa_a == 10'd100) break;
      tick();
    end
    chk("reach_blk100",
        !ov_a && ma_a != 0 && oa_a == 10'd100, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_valid", ov_a, 0);
    chk("mid_rst_pixel", px_a, 0);
    chk("mid_rst_out_addr", oa_a, 0);
    chk("mid_rst_mem_addr", ma_a, 0);
    reset = 1'b0;
    chk("acc_before_rst", n_acc_a - base_acc, 100);
    qa.delete();
    repeat (10) tick();
    chk("no_resume_busy", busy_a, 0);
    chk("no_resume_done", done_cnt_a - base_done, 0);
    push_frame(0);
    base_acc  = n_acc_a;
    base_done = done_cnt_a;
    start_a   = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ov_a) break;
      tick();
    end
    chk("restart_addr0", oa_a, 0);
    wait_done(0, base_done + 1, 6000);
    repeat (3) tick();
    chk("restart_outputs", n_acc_a - base_acc, 784);
    chk("restart_queue_empty", qa.size(), 0);

    // B=4 checkerboard with read address trace
    for (int y = 0; y < 56; y++)
      for (int x = 0; x < 56; x++)
        mem_b[y*56 + x] = 1'((x + y) & 1);
    push_frame(1);
    base_acc  = n_acc_b;
    base_done = done_cnt_b;
    mon_b     = 1'b1;
    start_b   = 1'b1;
    tick();
    start_b = 1'b0;
    for (int j = 0; j < 196; j++) begin
      for (int k = 0; k < 16; k++) begin
        chk("b4_mem_addr", ma_b,
            ((j/14)*4 + k/4)*56 + (j%14)*4 + k%4);
        tick();
      end
      repeat (3) tick();
    end
    wait_done(1, base_done + 1, 50);
    repeat (3) tick();
    chk("b4_outputs", n_acc_b - base_acc, 196);
    chk("b4_done_once", done_cnt_b - base_done, 1);
    chk("b4_queue_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
